main_fsm: RTL
=============

// Module: main_fsm
// PURPOSE
//  Multicycle main control FSM: sequences fetch/decode/execute/writeback and drives the
//  per-cycle control strobes. Sits upstream of the conditional-execution logic, which
//  qualifies NextPC, RegW and MemW with the condition result. Adds a MemReady handshake
//  so fetch and data-memory states stall until the memory accepts or returns data.
// PARAMETERS
//  CNT_W  32  width of the performance counters (used only when MAINFSM_PERFCNT_EN is set)
// PORTS
//  clk        in   1  single clock, rising edge
//  reset      in   1  synchronous, active-high
//  Op         in   2  instr[27:26]: 00 data-proc, 01 mem, 10 branch, 11 illegal
//  Funct      in   6  instr[25:20]: [5]=I (immediate), [0]=L (load) for mem ops
//  MemReady   in   1  memory done/accepting this cycle
//  IRWrite    out  1  load instruction register
//  AdrSrc     out  1  0=PC, 1=ALU result as memory address
//  ALUSrcA    out  2  00=RegA, 01=PC, 10=ALUOut
//  ALUSrcB    out  2  00=RegB, 01=ExtImm, 10=const 4
//  ALUOp      out  1  1=decode ALU op from Funct, 0=add
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALU result
//  NextPC     out  1  PC update request (pre-CondEx)
//  RegW       out  1  register write request (pre-CondEx)
//  MemW       out  1  memory write request (pre-CondEx)
//  Branch     out  1  branch state active
//  IllegalOp  out  1  one-cycle pulse on Op=11
// BEHAVIOUR
//  - State register only; all outputs Moore-decoded from state, plus MemReady gating.
//  - Reset: state<=FETCH. While reset=1, IRWrite/NextPC/RegW/MemW/Branch/IllegalOp=0.
//    Reset mid-instruction abandons it; the next cycle after release is FETCH.
//  - Unlisted outputs are 0 (AdrSrc/ALUSrc*/ResultSrc=00).
//  - FETCH: AdrSrc=0 ALUSrcA=01 ALUSrcB=10 ResultSrc=10; IRWrite=NextPC=MemReady.
//    Stay while !MemReady; ->DECODE on MemReady.
//  - DECODE: ALUSrcA=01 ALUSrcB=10 ResultSrc=10. Op=01->MEMADR; Op=00 & !Funct[5]->EXECR;
//    Op=00 & Funct[5]->EXECI; Op=10->BRANCH; Op=11->UNKNOWN.
//  - MEMADR: ALUSrcB=01. Funct[0]=1->MEMREAD else ->MEMWRITE.
//  - MEMREAD: AdrSrc=1. Stay until MemReady; then ->MEMWB.
//  - MEMWB: ResultSrc=01 RegW=1 ->FETCH.
//  - MEMWRITE: AdrSrc=1 MemW=1 (held every cycle until MemReady); ->FETCH on MemReady.
//  - EXECR: ALUOp=1 ->ALUWB. EXECI: ALUSrcB=01 ALUOp=1 ->ALUWB. ALUWB: RegW=1 ->FETCH.
//  - BRANCH: ALUSrcA=10 ALUSrcB=01 ResultSrc=10 Branch=1 ->FETCH.
//  - UNKNOWN: IllegalOp=1 for exactly one cycle, no write strobes, ->FETCH.
//  - Latency (MemReady=1 throughout): DP 4, branch 3, load 5, store 4 cycles.
//  - Op/Funct are sampled only in DECODE/MEMADR; they must be stable from IR then.
//  - State encoding has no unreachable-state lockup: any illegal encoding ->FETCH.
// CONFIGURATION
//  MAINFSM_PERFCNT_EN defined: adds outputs CycleCnt[CNT_W-1:0], InstrCnt[CNT_W-1:0].
//    Both are cleared by reset. CycleCnt increments every non-reset cycle.
//    InstrCnt increments on each exit into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or
//    UNKNOWN. Both wrap modulo 2^CNT_W.
//  Not defined: ports and counter logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package main_fsm_pkg: state enum (FETCH..UNKNOWN); ALUSrcA/B and ResultSrc encoding
//  constants; Op codes OP_DP/OP_MEM/OP_BR.
//  Sub-module main_fsm_outdec: pure combinational state->control-word decode;
//  next-state logic and counters stay in main_fsm.
// TESTING
//  1 reset held 3 cycles, MemReady=1 -> all strobes 0 during reset; FETCH next cycle with IRWrite=NextPC=1.
//  2 Op=00 Funct=6'b000100 -> FETCH,DECODE,EXECR,ALUWB; RegW=1 only in cycle 4.
//    Funct[5]=1 -> EXECI with ALUSrcB=01.
//  3 Op=01 Funct[0]=1, MemReady low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, then MEMWB RegW=1 ResultSrc=01.
//  4 Op=01 Funct[0]=0, MemReady low 1 cycle -> MemW=1 for 2 cycles; FETCH follows.
//  5 FETCH with MemReady=0 for 4 cycles -> IRWrite=NextPC=0 for 4 cycles, single 1-cycle pulse on ready.
//  6 Op=11 -> IllegalOp one pulse, no RegW/MemW.
//    PERFCNT_EN: after tests 2+6, InstrCnt=2; CNT_W=4 wraps 15->0.

Source files
------------

// File: rtl/main_fsm_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
package main_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/main_fsm_if.sv
// Control/handshake bundle between the main FSM (master) and the datapath/memory (slave).
// MemReady: the memory asserts it in any cycle it accepts a write or returns fetch/load
// data; the FSM holds its request (address select, MemW) unchanged until that cycle.
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ALUOp;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       IllegalOp;

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
           NextPC, RegW, MemW, Branch, IllegalOp
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
           NextPC, RegW, MemW, Branch, IllegalOp
  );
endinterface

// File: rtl/main_fsm_outdec.sv
// Combinational state -> control-word decode; MemReady only qualifies the fetch strobes.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.next_pc    = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      MEMADR:  ctrl.alu_src_b = SRCB_IMM;
      MEMREAD: ctrl.adr_src   = 1'b1;
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      EXECR: ctrl.alu_op = 1'b1;
      EXECI: begin
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
      end
      ALUWB: ctrl.reg_w = 1'b1;
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_ALUOUT;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
      end
      UNKNOWN: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM with MemReady stalls in fetch and data-memory states.
// Optional performance counters (CycleCnt/InstrCnt) when MAINFSM_PERFCNT_EN is defined.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  main_fsm_if.master        bus,
`ifdef MAINFSM_PERFCNT_EN
  output logic [CNT_W-1:0]  CycleCnt,
  output logic [CNT_W-1:0]  InstrCnt,
`endif
  output state_t            dbg_state
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   strobe_en;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (bus.MemReady) state_next = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = bus.Funct[5] ? EXECI : EXECR;
          OP_BR:   state_next = BRANCH;
          default: state_next = UNKNOWN;
        endcase
      end
      MEMADR:   state_next = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.MemReady) state_next = MEMWB;
      MEMWRITE: if (bus.MemReady) state_next = FETCH;
      EXECR,
      EXECI:    state_next = ALUWB;
      MEMWB,
      ALUWB,
      BRANCH,
      UNKNOWN:  state_next = FETCH;
      // Any encoding outside the enum recovers straight into fetch.
      default:  state_next = FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state     (state),
    .mem_ready (bus.MemReady),
    .ctrl      (ctrl)
  );

  // Write/side-effect strobes are forced low for the whole reset window.
  assign strobe_en     = ~reset;
  assign bus.IRWrite   = ctrl.ir_write   & strobe_en;
  assign bus.NextPC    = ctrl.next_pc    & strobe_en;
  assign bus.RegW      = ctrl.reg_w      & strobe_en;
  assign bus.MemW      = ctrl.mem_w      & strobe_en;
  assign bus.Branch    = ctrl.branch     & strobe_en;
  assign bus.IllegalOp = ctrl.illegal_op & strobe_en;
  assign bus.AdrSrc    = ctrl.adr_src;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.ResultSrc = ctrl.result_src;
  assign dbg_state     = state;

  logic unused_funct;
  assign unused_funct = ^bus.Funct[4:1];

`ifdef MAINFSM_PERFCNT_EN
  logic instr_done;

  always_comb begin
    instr_done = 1'b0;
    case (state)
      MEMWB, ALUWB, BRANCH, UNKNOWN: instr_done = 1'b1;
      MEMWRITE:                      instr_done = bus.MemReady;
      default:                       instr_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      CycleCnt <= CycleCnt + CNT_W'(1);
      if (instr_done) InstrCnt <= InstrCnt + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
